// File: rtl/mem_stage_axi.sv
// MIPS memory-access stage: one single-beat AXI4-Lite read or write per request.
// Stalls the pipeline while a transaction is outstanding and reports a one-cycle completion.
module mem_stage_axi #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    req_ready,
    output logic                    stall,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [1:0]              bresp,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp
);

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA,
        RESP
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;
    logic                    aw_done;
    logic                    w_done;
    logic                    accept;
    logic                    misaligned;
    logic                    aw_hs;
    logic                    w_hs;

    assign misaligned = (req_addr[1:0] != 2'b00);
    assign accept     = req_valid && req_ready;
    assign aw_hs      = awvalid && awready;
    assign w_hs       = wvalid && wready;

    assign awaddr     = addr_q;
    assign araddr     = addr_q;
    assign wdata      = wdata_q;
    assign wstrb      = '1;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state and state-decoded handshake outputs
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (misaligned)  state_d = RESP;
                    else if (req_we) state_d = WADDR;
                    else             state_d = RADDR;
                end
            end
            WADDR: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || awready) && (w_done || wready))
                    state_d = WRESP;
            end
            WRESP: begin
                bready = 1'b1;
                if (bvalid) state_d = RESP;
            end
            RADDR: begin
                arvalid = 1'b1;
                if (arready) state_d = RDATA;
            end
            RDATA: begin
                rready = 1'b1;
                if (rvalid) state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        stall = !req_ready;
    end

    // Latch word-aligned address and store data on an aligned accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept && !misaligned) begin
            addr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            wdata_q <= req_wdata;
        end
    end

    // Sticky AW/W completion flags, cleared whenever idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state_q == IDLE) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
        end
    end

    // Capture completion status and load data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept && misaligned)
                err_q <= 1'b1;
            if (state_q == WRESP && bvalid)
                err_q <= (bresp != 2'b00);
            if (state_q == RDATA && rvalid) begin
                err_q   <= (rresp != 2'b00);
                rdata_q <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_axi.sv
// Directed bench for mem_stage_axi with an AXI4-Lite slave model
// that has per-channel wait states and a small word memory.
module tb_mem_stage_axi;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    mem_stage_axi #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .stall(stall),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .rresp(rresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // slave configuration
    int         aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic [1:0] cfg_bresp, cfg_rresp;

    // slave state
    logic [31:0] mem [0:255];
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic        s_aw_got, s_w_got, s_ar_got;
    logic [31:0] s_awaddr, s_wdata, s_araddr;

    assign awready = awvalid && (aw_cnt >= aw_wait);
    assign wready  = wvalid && (w_cnt >= w_wait);
    assign bvalid  = s_aw_got && s_w_got && (b_cnt >= b_wait);
    assign bresp   = bvalid ? cfg_bresp : 2'b00;
    assign arready = arvalid && (ar_cnt >= ar_wait);
    assign rvalid  = s_ar_got && (r_cnt >= r_wait);
    assign rdata   = rvalid ? mem[s_araddr[9:2]] : 32'h0;
    assign rresp   = rvalid ? cfg_rresp : 2'b00;

    // slave model, reset together with the stage
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
            ar_cnt <= 0; r_cnt <= 0;
            s_aw_got <= 1'b0; s_w_got <= 1'b0; s_ar_got <= 1'b0;
            s_awaddr <= '0; s_wdata <= '0; s_araddr <= '0;
        end else begin
            if (awvalid && awready) begin
                aw_cnt <= 0; s_aw_got <= 1'b1; s_awaddr <= awaddr;
            end else if (awvalid) aw_cnt <= aw_cnt + 1;
            if (wvalid && wready) begin
                w_cnt <= 0; s_w_got <= 1'b1; s_wdata <= wdata;
            end else if (wvalid) w_cnt <= w_cnt + 1;
            if (bvalid && bready) begin
                s_aw_got <= 1'b0; s_w_got <= 1'b0; b_cnt <= 0;
                mem[s_awaddr[9:2]] <= s_wdata;
            end else if (s_aw_got && s_w_got) b_cnt <= b_cnt + 1;
            if (arvalid && arready) begin
                ar_cnt <= 0; s_ar_got <= 1'b1; s_araddr <= araddr;
            end else if (arvalid) ar_cnt <= ar_cnt + 1;
            if (rvalid && rready) begin
                s_ar_got <= 1'b0; r_cnt <= 0;
            end else if (s_ar_got) r_cnt <= r_cnt + 1;
        end
    end

    // protocol monitor
    int          rv_cnt, ar_seen, bus_seen, proto_err;
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [31:0] p_awaddr, p_wdata, p_araddr;

    always @(negedge clk) begin
        if (reset_n) begin
            if (resp_valid) rv_cnt <= rv_cnt + 1;
            if (arvalid) ar_seen <= ar_seen + 1;
            if (awvalid || wvalid || arvalid) bus_seen <= bus_seen + 1;
            if ((stall !== !req_ready)
                || (bready && !(s_aw_got && s_w_got))
                || (rready && !s_ar_got)
                || (p_awv && !p_awr && (!awvalid || awaddr !== p_awaddr))
                || (p_wv && !p_wr && (!wvalid || wdata !== p_wdata))
                || (p_arv && !p_arr && (!arvalid || araddr !== p_araddr))
                || (p_awv && p_awr && awvalid)
                || (p_wv && p_wr && wvalid)
                || (p_arv && p_arr && arvalid))
                proto_err <= proto_err + 1;
            p_awv <= awvalid; p_awr <= awready; p_awaddr <= awaddr;
            p_wv <= wvalid; p_wr <= wready; p_wdata <= wdata;
            p_arv <= arvalid; p_arr <= arready; p_araddr <= araddr;
        end else begin
            p_awv <= 1'b0; p_wv <= 1'b0; p_arv <= 1'b0;
            p_awr <= 1'b0; p_wr <= 1'b0; p_arr <= 1'b0;
        end
    end

    int n_chk;
    int n_fail;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        int          aw_w, w_w, b_w, ar_w, r_w;
        logic [1:0]  br, rr;
        int          lat;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    task automatic run_vec(input vec_t v, input int idx);
        int  lat;
        int  rv0, ar0, bus0, pe0;
        bit  stall_ok;
        aw_wait = v.aw_w; w_wait = v.w_w; b_wait = v.b_w;
        ar_wait = v.ar_w; r_wait = v.r_w;
        cfg_bresp = v.br; cfg_rresp = v.rr;
        @(negedge clk);
        chk($sformatf("v%0d idle ready", idx), req_ready, 1);
        rv0 = rv_cnt; ar0 = ar_seen; bus0 = bus_seen; pe0 = proto_err;
        req_valid = 1'b1; req_we = v.we;
        req_addr = v.addr; req_wdata = v.wd;
        @(negedge clk);
        req_valid = 1'b0;
        if (v.addr[1:0] == 2'b00) begin
            if (v.we) begin
                chk($sformatf("v%0d awvalid", idx), awvalid, 1);
                chk($sformatf("v%0d wvalid", idx), wvalid, 1);
                chk($sformatf("v%0d awaddr", idx), awaddr, v.addr);
                chk($sformatf("v%0d wdata", idx), wdata, v.wd);
                chk($sformatf("v%0d wstrb", idx), wstrb, 4'hF);
            end else begin
                chk($sformatf("v%0d arvalid", idx), arvalid, 1);
                chk($sformatf("v%0d araddr", idx), araddr, v.addr);
            end
        end
        lat = 1;
        stall_ok = 1'b1;
        while (!resp_valid && lat < 64) begin
            if (!stall) stall_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk($sformatf("v%0d latency", idx), lat, v.lat);
        chk($sformatf("v%0d resp_err", idx), resp_err, v.err);
        chk($sformatf("v%0d resp_rdata", idx), resp_rdata, v.rd);
        chk($sformatf("v%0d stall held", idx), stall_ok, 1);
        @(negedge clk);
        chk($sformatf("v%0d pulse width", idx), resp_valid, 0);
        chk($sformatf("v%0d ready again", idx), req_ready, 1);
        chk($sformatf("v%0d resp count", idx), rv_cnt - rv0, 1);
        chk($sformatf("v%0d protocol", idx), proto_err - pe0, 0);
        if (v.addr[1:0] != 2'b00)
            chk($sformatf("v%0d no bus", idx), bus_seen - bus0, 0);
        if (v.we)
            chk($sformatf("v%0d no arvalid", idx), ar_seen - ar0, 0);
    endtask

    vec_t vecs[8];
    vec_t rv;

    initial begin
        int t, first_b, rv0, resp1, acc2;
        n_chk = 0; n_fail = 0;
        rv_cnt = 0; ar_seen = 0; bus_seen = 0; proto_err = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        cfg_bresp = 2'b00; cfg_rresp = 2'b00;
        req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[32'h104 >> 2] = 32'h12345678;

        //          we    addr    wdata         aw w b ar r  br     rr     lat err  rdata
        vecs[0] = '{1'b1, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h104, 32'h0,        0, 0, 0, 0, 4, 2'b00, 2'b00, 7, 1'b0, 32'h12345678};
        vecs[2] = '{1'b0, 32'h102, 32'h0,        0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1'b1, 32'h12345678};
        vecs[3] = '{1'b1, 32'h108, 32'h55AA55AA, 0, 0, 0, 0, 0, 2'b10, 2'b00, 3, 1'b1, 32'h12345678};
        vecs[4] = '{1'b1, 32'h101, 32'h11111111, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1'b1, 32'h12345678};
        vecs[5] = '{1'b0, 32'h100, 32'h0,        0, 0, 0, 0, 0, 2'b00, 2'b11, 3, 1'b1, 32'hDEADBEEF};
        vecs[6] = '{1'b1, 32'h10C, 32'hCAFEF00D, 2, 1, 1, 0, 0, 2'b00, 2'b00, 6, 1'b0, 32'hDEADBEEF};
        vecs[7] = '{1'b0, 32'h10C, 32'h0,        0, 0, 0, 2, 0, 2'b00, 2'b00, 5, 1'b0, 32'hCAFEF00D};

        // reset state
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst req_ready", req_ready, 1);
        chk("rst stall", stall, 0);
        chk("rst resp_valid", resp_valid, 0);
        chk("rst resp_err", resp_err, 0);
        chk("rst resp_rdata", resp_rdata, 0);
        chk("rst valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
        chk("rst awaddr", awaddr, 0);
        chk("rst araddr", araddr, 0);
        chk("rst wdata", wdata, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // split write: W handshakes 3 cycles before AW
        aw_wait = 3; w_wait = 0; b_wait = 0;
        cfg_bresp = 2'b00;
        @(negedge clk);
        rv0 = rv_cnt;
        req_valid = 1'b1; req_we = 1'b1;
        req_addr = 32'h300; req_wdata = 32'h0BADF00D;
        @(negedge clk);
        req_valid = 1'b0;
        chk("split both valid", {awvalid, wvalid, bready}, 3'b110);
        @(negedge clk);
        chk("split w dropped", {awvalid, wvalid, bready}, 3'b100);
        t = 2; first_b = 0;
        while (!resp_valid && t < 40) begin
            if (bready && first_b == 0) first_b = t;
            @(negedge clk);
            t++;
        end
        chk("split bready start", first_b, 5);
        chk("split latency", t, 6);
        chk("split err", resp_err, 0);
        repeat (3) @(negedge clk);
        chk("split one resp", rv_cnt - rv0, 1);
        chk("split mem", mem[32'h300 >> 2], 32'h0BADF00D);

        // reset during RDATA
        aw_wait = 0; ar_wait = 0; r_wait = 20;
        cfg_rresp = 2'b00;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h104;
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (!rready && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("rdata reached", rready, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
        chk("midrst req_ready", req_ready, 1);
        chk("midrst resp_valid", resp_valid, 0);
        chk("midrst rdata", resp_rdata, 0);
        @(negedge clk);
        reset_n = 1'b1;
        rv = '{1'b0, 32'h104, 32'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3, 1'b0, 32'h12345678};
        run_vec(rv, 8);

        // back-to-back sw then lw to 0x200
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1;
        req_addr = 32'h200; req_wdata = 32'hA5A50F0F;
        @(negedge clk);
        req_we = 1'b0; req_wdata = 32'h0;
        t = 1; resp1 = 0; acc2 = 0;
        while (acc2 == 0 && t < 40) begin
            if (resp_valid && resp1 == 0) resp1 = t;
            if (req_ready) acc2 = t;
            else begin
                @(negedge clk);
                t++;
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b first resp", resp1, 3);
        chk("b2b second accept", acc2, 4);
        t = 1;
        while (!resp_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("b2b load latency", t, 3);
        chk("b2b load data", resp_rdata, 32'hA5A50F0F);
        chk("b2b load err", resp_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
